// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing controller for a direct-mapped, write-back,
// one-byte-per-line data cache. It turns CPU byte loads and stores into
// cache command sequences, writes dirty victims back to RAM, fills on a
// load miss, serves whole-cache flushes and keeps hit/miss counters.
module dm_cache_ctrl #(
    parameter int addrWidth     = 8,
    parameter int dataWidth     = 8,
    parameter int blockAddrBits = 4,
    parameter int cntWidth      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpuReq,
    input  logic                 cpuWe,
    input  logic [addrWidth-1:0] cpuAddr,
    input  logic [dataWidth-1:0] cpuWData,
    output logic [dataWidth-1:0] cpuRData,
    output logic                 cpuReady,
    output logic                 busy,
    input  logic                 flushReq,
    output logic                 flushDone,
    output logic [1:0]           cacheCntrl,
    output logic [addrWidth-1:0] cacheAddr,
    output logic [dataWidth-1:0] cacheDataIn,
    input  logic [dataWidth-1:0] cacheDataOut,
    input  logic                 cacheIsHit,
    input  logic                 cacheIsClean,
    input  logic [addrWidth-1:0] cacheAddrOutRAM,
    input  logic [dataWidth-1:0] cacheDataOutRAM,
    output logic                 ramReq,
    output logic                 ramWe,
    output logic [addrWidth-1:0] ramAddr,
    output logic [dataWidth-1:0] ramWData,
    input  logic [dataWidth-1:0] ramRData,
    input  logic                 ramAck,
    output logic [cntWidth-1:0]  hitCount,
    output logic [cntWidth-1:0]  missCount
);

    // The index must leave at least one tag bit.
    if (blockAddrBits < 1 || blockAddrBits >= addrWidth) begin : g_bad_cfg
        $error("dm_cache_ctrl: blockAddrBits must be in 1..addrWidth-1");
    end

    localparam logic [1:0] CMD_CLR    = 2'b00;
    localparam logic [1:0] CMD_STATUS = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [1:0] CMD_WRITE  = 2'b11;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_CLR, S_CHECK, S_WB, S_FILL, S_INSTALL, S_READ, S_WRITE
    } state_t;

    state_t               state;
    logic [addrWidth-1:0] reqAddr;
    logic                 reqWe;
    logic [dataWidth-1:0] reqWData;
    logic [addrWidth-1:0] vicAddr;
    logic [dataWidth-1:0] vicData;
    logic [dataWidth-1:0] fillData;

    // Main sequencer: state, request/victim latches, pulses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            reqAddr   <= '0;
            reqWe     <= 1'b0;
            reqWData  <= '0;
            vicAddr   <= '0;
            vicData   <= '0;
            fillData  <= '0;
            cpuRData  <= '0;
            cpuReady  <= 1'b0;
            flushDone <= 1'b0;
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            cpuReady  <= 1'b0;
            flushDone <= 1'b0;
            case (state)
                S_INIT: state <= S_IDLE;
                S_IDLE: begin
                    if (flushReq) begin
                        state <= S_CLR;
                    end else if (cpuReq) begin
                        reqAddr  <= cpuAddr;
                        reqWe    <= cpuWe;
                        reqWData <= cpuWData;
                        state    <= S_CHECK;
                    end
                end
                S_CLR: begin
                    flushDone <= 1'b1;
                    state     <= S_IDLE;
                end
                S_CHECK: begin
                    vicAddr <= cacheAddrOutRAM;
                    vicData <= cacheDataOutRAM;
                    if (cacheIsHit) begin
                        if (hitCount != '1) hitCount <= hitCount + 1'b1;
                        state <= reqWe ? S_WRITE : S_READ;
                    end else begin
                        if (missCount != '1) missCount <= missCount + 1'b1;
                        if (!cacheIsClean) state <= S_WB;
                        else               state <= reqWe ? S_WRITE : S_FILL;
                    end
                end
                S_WB: begin
                    if (ramAck) state <= reqWe ? S_WRITE : S_FILL;
                end
                S_FILL: begin
                    if (ramAck) begin
                        fillData <= ramRData;
                        state    <= S_INSTALL;
                    end
                end
                S_INSTALL: begin
                    cpuRData <= fillData;
                    cpuReady <= 1'b1;
                    state    <= S_IDLE;
                end
                S_READ: begin
                    cpuRData <= cacheDataOut;
                    cpuReady <= 1'b1;
                    state    <= S_IDLE;
                end
                S_WRITE: begin
                    cpuReady <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Cache and RAM drive decoded from registered state only, so they are
    // settled well before the cache samples on the falling edge.
    always_comb begin
        cacheCntrl  = CMD_STATUS;
        cacheDataIn = reqWData;
        ramReq      = 1'b0;
        ramWe       = 1'b0;
        ramAddr     = reqAddr;
        ramWData    = vicData;
        case (state)
            S_INIT, S_CLR: cacheCntrl = CMD_CLR;
            S_READ:        cacheCntrl = CMD_READ;
            S_WRITE:       cacheCntrl = CMD_WRITE;
            S_INSTALL: begin
                cacheCntrl  = CMD_WRITE;
                cacheDataIn = fillData;
            end
            S_WB: begin
                ramReq  = 1'b1;
                ramWe   = 1'b1;
                ramAddr = vicAddr;
            end
            S_FILL: ramReq = 1'b1;
            default: ;
        endcase
    end

    assign cacheAddr = reqAddr;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: drives dm_cache_ctrl against a command-level cache model
// and a RAM with random ack delays, and checks every transaction against a
// transaction-level reference of cache contents, RAM contents and counters.
module tb_dm_cache_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IB = 4;
    localparam int CW = 4;   // narrow counters so saturation is reachable
    localparam int NL = 1 << IB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cpuReq = 1'b0, cpuWe = 1'b0, flushReq = 1'b0;
    logic [AW-1:0] cpuAddr = '0;
    logic [DW-1:0] cpuWData = '0;
    logic [DW-1:0] cpuRData;
    logic          cpuReady, busy, flushDone;
    logic [1:0]    cacheCntrl;
    logic [AW-1:0] cacheAddr, cacheAddrOutRAM;
    logic [DW-1:0] cacheDataIn, cacheDataOut, cacheDataOutRAM;
    logic          cacheIsHit, cacheIsClean;
    logic          ramReq, ramWe, ramAck;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWData, ramRData;
    logic [CW-1:0] hitCount, missCount;

    dm_cache_ctrl #(.addrWidth(AW), .dataWidth(DW), .blockAddrBits(IB), .cntWidth(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuRData(cpuRData), .cpuReady(cpuReady), .busy(busy),
        .flushReq(flushReq), .flushDone(flushDone),
        .cacheCntrl(cacheCntrl), .cacheAddr(cacheAddr), .cacheDataIn(cacheDataIn),
        .cacheDataOut(cacheDataOut), .cacheIsHit(cacheIsHit), .cacheIsClean(cacheIsClean),
        .cacheAddrOutRAM(cacheAddrOutRAM), .cacheDataOutRAM(cacheDataOutRAM),
        .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
        .ramRData(ramRData), .ramAck(ramAck),
        .hitCount(hitCount), .missCount(missCount)
    );

    // ---- cache model: acts on the command seen at the falling edge ----
    logic [DW-1:0]    c_data [NL];
    logic [AW-IB-1:0] c_tag  [NL];
    logic             c_vld  [NL];
    logic             c_dty  [NL];
    wire  [IB-1:0]    cidx = cacheAddr[IB-1:0];

    assign cacheIsHit      = c_vld[cidx] && (c_tag[cidx] == cacheAddr[AW-1:IB]);
    assign cacheIsClean    = !(c_vld[cidx] && c_dty[cidx]);
    assign cacheAddrOutRAM = {c_tag[cidx], cidx};
    assign cacheDataOutRAM = c_data[cidx];
    assign cacheDataOut    = c_data[cidx];

    always @(negedge clk) begin
        if (cacheCntrl == 2'b00) begin
            for (int i = 0; i < NL; i++) begin c_vld[i] = 1'b0; c_dty[i] = 1'b0; end
        end else if (cacheCntrl == 2'b11) begin
            c_vld[cidx]  = 1'b1;
            c_dty[cidx]  = 1'b1;
            c_tag[cidx]  = cacheAddr[AW-1:IB];
            c_data[cidx] = cacheDataIn;
        end
    end

    // ---- RAM model: random/fixed ack delay, optional spurious acks ----
    logic [DW-1:0] e_ram [256];
    int            ram_fix = -1;
    bit            ram_hold = 1'b0, spur_en = 1'b0;
    int            rcnt, rdly, nwr, nrd;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] last_wd;

    initial begin
        for (int i = 0; i < 256; i++) e_ram[i] = 8'(i * 37 + 11);
        e_ram[8'h35] = 8'hA7;
        ramAck = 1'b0; ramRData = '0;
        rcnt = 0; rdly = 1; nwr = 0; nrd = 0; last_wa = '0; last_wd = '0;
        forever begin
            @(negedge clk);
            if (ramAck) begin
                ramAck = 1'b0;
                rcnt   = 0;
            end else if (ramReq && !ram_hold) begin
                if (rcnt >= ((ram_fix >= 0) ? ram_fix : rdly)) begin
                    ramAck = 1'b1;
                    if (ramWe) begin
                        e_ram[ramAddr] = ramWData;
                        last_wa = ramAddr; last_wd = ramWData; nwr++;
                        ramRData = 8'($urandom);
                    end else begin
                        ramRData = e_ram[ramAddr]; nrd++;
                    end
                    rdly = $urandom_range(0, 3);
                end else begin
                    rcnt++;
                end
            end else if (!ramReq) begin
                rcnt = 0;
                if (spur_en && $urandom_range(0, 7) == 0) begin
                    ramAck = 1'b1; ramRData = 8'($urandom);
                end
            end
        end
    end

    // ---- reference: what the CPU-visible memory system should do ----
    logic [DW-1:0]    r_data [NL];
    logic [AW-IB-1:0] r_tag  [NL];
    bit               r_vld  [NL];
    bit               r_dty  [NL];
    logic [DW-1:0]    r_ram  [256];
    int               r_hit, r_miss;
    int               checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < NL; i++) begin r_vld[i] = 0; r_dty[i] = 0; end
    endtask

    // One CPU access, started at a falling edge with the controller idle
    // (or showing cpuReady); returns at the falling edge showing cpuReady.
    task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic [IB-1:0]    ix = a[IB-1:0];
        logic [AW-IB-1:0] tg = a[AW-1:IB];
        bit               hit, wb;
        logic [AW-1:0]    wb_a;
        logic [DW-1:0]    wb_d, exp_rd;
        int               wr0, rd0, n, busyc, ramc;
        logic [1:0]       first_c, last_c;

        hit = r_vld[ix] && r_tag[ix] == tg;
        wb  = !hit && r_vld[ix] && r_dty[ix];
        wb_a = {r_tag[ix], ix}; wb_d = r_data[ix];
        if (hit) r_hit = sat_inc(r_hit);
        else     r_miss = sat_inc(r_miss);
        if (wb) r_ram[wb_a] = wb_d;
        if (we)        r_data[ix] = wd;
        else if (!hit) r_data[ix] = r_ram[a];
        r_vld[ix] = 1; r_dty[ix] = 1; r_tag[ix] = tg;
        exp_rd = r_data[ix];

        wr0 = nwr; rd0 = nrd;
        cpuReq = 1'b1; cpuWe = we; cpuAddr = a; cpuWData = wd;
        @(negedge clk);
        cpuReq = 1'b0;
        n = 0; busyc = 0; ramc = 0; first_c = 2'bxx; last_c = 2'bxx;
        while (!cpuReady && n < 200) begin
            if (busy) busyc++;
            if (ramReq) ramc++;
            if (n == 0) first_c = cacheCntrl;
            last_c = cacheCntrl;
            @(negedge clk);
            n++;
        end
        chk("timeout", 32'(n < 200), 1);
        chk("latency", busyc, 2 + ramc);
        chk("cntrl_check", 32'(first_c), 1);
        chk("cntrl_last", 32'(last_c), (hit && !we) ? 2 : 3);
        chk("idle_at_ready", 32'(busy), 0);
        if (!we) chk("rdata", 32'(cpuRData), 32'(exp_rd));
        chk("ram_writes", nwr - wr0, wb ? 1 : 0);
        chk("ram_reads", nrd - rd0, (!hit && !we) ? 1 : 0);
        if (wb) begin
            chk("wb_addr", 32'(last_wa), 32'(wb_a));
            chk("wb_data", 32'(last_wd), 32'(wb_d));
        end
        chk("hitcount", 32'(hitCount), r_hit);
        chk("misscount", 32'(missCount), r_miss);
    endtask

    // Flush from idle; leaves cpuReq untouched so a held request follows.
    task automatic do_flush();
        flushReq = 1'b1;
        @(negedge clk);
        chk("flush_clr", 32'(cacheCntrl), 0);
        chk("flush_busy", 32'(busy), 1);
        flushReq = 1'b0;
        @(negedge clk);
        chk("flush_done", 32'(flushDone), 1);
        ref_clear();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) r_ram[i] = 8'(i * 37 + 11);
        r_ram[8'h35] = 8'hA7;
        ref_clear(); r_hit = 0; r_miss = 0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_cntrl", 32'(cacheCntrl), 0);
        chk("rst_ramreq", 32'(ramReq), 0);
        chk("rst_ready", 32'(cpuReady), 0);
        chk("rst_hits", 32'(hitCount), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_to_idle", 32'(busy), 0);
        chk("init_no_flushdone", 32'(flushDone), 0);

        // directed walk-through
        do_op(1'b0, 8'h35, 8'h00);   // clean load miss, fill 0xA7
        do_op(1'b0, 8'h35, 8'h00);   // hit
        do_op(1'b1, 8'h45, 8'h12);   // dirty store miss: WB 0x35, no fill
        ram_fix = 5;
        do_op(1'b0, 8'h75, 8'h00);   // dirty load miss, slow RAM
        ram_fix = -1;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 8'h45;
        do_flush();                  // flush wins over the held request
        do_op(1'b0, 8'h45, 8'h00);   // misses after flush

        // random traffic over a few indices to mix hits, misses, evictions
        spur_en = 1'b1;
        for (int k = 0; k < 160; k++) begin
            if ($urandom_range(0, 15) == 0) do_flush();
            else do_op(1'($urandom_range(0, 1)),
                       8'(($urandom_range(0, 3) << IB) | $urandom_range(0, 3)),
                       8'($urandom));
        end
        spur_en = 1'b0;

        // reset in the middle of a writeback
        do_op(1'b1, 8'h09, 8'h5A);
        ram_hold = 1'b1;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 8'h19;
        @(negedge clk);
        cpuReq = 1'b0;
        n = 0;
        while (!(ramReq && ramWe) && n < 20) begin @(negedge clk); n++; end
        chk("wb_seen", 32'(ramReq && ramWe), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_drops_ramreq", 32'(ramReq), 0);
        @(negedge clk);
        rst_n = 1'b1; ram_hold = 1'b0;
        #1;
        chk("reinit_cntrl", 32'(cacheCntrl), 0);
        chk("reinit_hits", 32'(hitCount), 0);
        chk("reinit_misses", 32'(missCount), 0);
        ref_clear(); r_hit = 0; r_miss = 0;
        @(negedge clk);
        chk("reinit_idle", 32'(busy), 0);
        do_op(1'b0, 8'h19, 8'h00);   // RAM must hold the pre-abort value

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
